// File: rtl/alu_md_sequencer_if.sv
// Request/response handshake bundle between the EX stage and the RV32M multiply/divide sequencer.
interface alu_md_sequencer_if;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_illegal;

    modport master (
        output i_valid, i_op, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_result, o_illegal
    );

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_ready,
        output o_ready, o_valid, o_result, o_illegal
    );
endinterface

// File: rtl/alu_md_sequencer.sv
// Multi-cycle RV32M MUL/DIV/DIVU/REM/REMU sequencer that borrows the pipeline's shared 32-bit ALU.
// Optional feature macro: ALU_MD_SIGNED_EN (signed DIV/REM with pre/post negation).
module alu_md_sequencer (
    input  logic                 clk,
    input  logic                 rst,
    alu_md_sequencer_if.slave    bus,
    output logic                 o_busy,
    output logic [31:0]          o_alu_a,
    output logic [31:0]          o_alu_b,
    output logic [3:0]           o_alu_sel,
    input  logic [31:0]          i_alu_result
);
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_SUB  = 4'b0011;
    localparam logic [3:0] SEL_PASS = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE_A = 3'd1,
        ST_PRE_B = 3'd2,
        ST_ITER  = 3'd3,
        ST_POST  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t      state_r, next_state_s;
    logic [2:0]  op_r;
    logic [31:0] a_r, b_r, acc_r, a_orig_r, result_r;
    logic [4:0]  cnt_r;
    logic        sa_r, sb_r, dz_r, valid_r, illegal_r;

    logic        accept_s, is_mul_s, is_quot_s, is_rem_s, is_illegal_s;
    logic        is_signed_s, req_signed_s, neg_s, no_borrow_s;
    logic [32:0] r_sh_s;
    logic [31:0] raw_s, final_s;

    // During division a_r doubles as the quotient q and acc_r as the partial remainder r.
    assign accept_s     = bus.i_valid & (state_r == ST_IDLE);
    assign is_mul_s     = (op_r == 3'b000);
    assign is_quot_s    = op_r[2] & ~op_r[1];
    assign is_rem_s     = op_r[2] & op_r[1];
    assign is_illegal_s = ~op_r[2] & (op_r[1:0] != 2'b00);
`ifdef ALU_MD_SIGNED_EN
    assign is_signed_s  = op_r[2] & ~op_r[0];
    assign req_signed_s = bus.i_op[2] & ~bus.i_op[0];
    assign neg_s        = is_signed_s & (is_quot_s ? (sa_r ^ sb_r) : sa_r);
`else
    assign is_signed_s  = 1'b0;
    assign req_signed_s = 1'b0;
    assign neg_s        = 1'b0;
`endif
    assign r_sh_s       = {acc_r, a_r[31]};
    assign no_borrow_s  = r_sh_s[32] | (r_sh_s[31:0] >= b_r);
    assign raw_s        = is_mul_s ? acc_r : (is_quot_s ? a_r : (is_rem_s ? acc_r : 32'h0000_0000));

    // Divide-by-zero overrides follow the RISC-V defined results; illegal requests return zero.
    always_comb begin
        if (is_illegal_s) begin
            final_s = 32'h0000_0000;
        end else if (dz_r && is_quot_s) begin
            final_s = 32'hFFFF_FFFF;
        end else if (dz_r && is_rem_s) begin
            final_s = a_orig_r;
        end else begin
            final_s = i_alu_result;
        end
    end

    assign bus.o_ready   = (state_r == ST_IDLE);
    assign bus.o_valid   = valid_r;
    assign bus.o_result  = result_r;
    assign bus.o_illegal = illegal_r;
    assign o_busy        = (state_r != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and ALU operand/select drive.
    always_comb begin
        next_state_s = state_r;
        o_alu_sel    = SEL_PASS;
        o_alu_a      = 32'h0000_0000;
        o_alu_b      = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef ALU_MD_SIGNED_EN
                    next_state_s = ST_PRE_A;
`else
                    next_state_s = ST_ITER;
`endif
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PRE_A: begin
                o_alu_sel    = (is_signed_s && sa_r) ? SEL_SUB : SEL_PASS;
                o_alu_b      = a_r;
                next_state_s = ST_PRE_B;
            end
            ST_PRE_B: begin
                o_alu_sel    = (is_signed_s && sb_r) ? SEL_SUB : SEL_PASS;
                o_alu_b      = b_r;
                next_state_s = ST_ITER;
            end
            ST_ITER: begin
                if (is_mul_s) begin
                    o_alu_sel = b_r[0] ? SEL_ADD : SEL_PASS;
                    o_alu_a   = b_r[0] ? acc_r : 32'h0000_0000;
                    o_alu_b   = b_r[0] ? a_r : acc_r;
                end else if (op_r[2]) begin
                    o_alu_sel = SEL_SUB;
                    o_alu_a   = r_sh_s[31:0];
                    o_alu_b   = b_r;
                end else begin
                    o_alu_sel = SEL_PASS;
                end
                next_state_s = (cnt_r == 5'd31) ? ST_POST : ST_ITER;
            end
            ST_POST: begin
                o_alu_sel    = neg_s ? SEL_SUB : SEL_PASS;
                o_alu_b      = raw_s;
                next_state_s = ST_DONE;
            end
            ST_DONE: begin
                next_state_s = (valid_r && bus.i_ready) ? ST_IDLE : ST_DONE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: operand capture, negation, shift-add / restoring-divide steps, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= 3'b000;
            a_r       <= 32'h0000_0000;
            b_r       <= 32'h0000_0000;
            acc_r     <= 32'h0000_0000;
            a_orig_r  <= 32'h0000_0000;
            result_r  <= 32'h0000_0000;
            cnt_r     <= 5'd0;
            sa_r      <= 1'b0;
            sb_r      <= 1'b0;
            dz_r      <= 1'b0;
            valid_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r     <= bus.i_op;
                        a_r      <= bus.i_a;
                        b_r      <= bus.i_b;
                        a_orig_r <= bus.i_a;
                        acc_r    <= 32'h0000_0000;
                        cnt_r    <= 5'd0;
                        sa_r     <= req_signed_s & bus.i_a[31];
                        sb_r     <= req_signed_s & bus.i_b[31];
                        dz_r     <= bus.i_op[2] & (bus.i_b == 32'h0000_0000);
                    end
                end
                ST_PRE_A: begin
                    if (is_signed_s && sa_r) begin
                        a_r <= i_alu_result;
                    end
                end
                ST_PRE_B: begin
                    if (is_signed_s && sb_r) begin
                        b_r <= i_alu_result;
                    end
                end
                ST_ITER: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (is_mul_s) begin
                        if (b_r[0]) begin
                            acc_r <= i_alu_result;
                        end
                        a_r <= {a_r[30:0], 1'b0};
                        b_r <= {1'b0, b_r[31:1]};
                    end else if (op_r[2]) begin
                        a_r   <= {a_r[30:0], no_borrow_s};
                        acc_r <= no_borrow_s ? i_alu_result : r_sh_s[31:0];
                    end
                end
                ST_POST: begin
                    result_r  <= final_s;
                    illegal_r <= is_illegal_s;
                end
                ST_DONE: begin
                    valid_r <= !(valid_r && bus.i_ready);
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
